pcileech_com_tx64to32: RTL and testbench
========================================

# pcileech_com_tx64to32

Serializes 64-bit words from the FPGA-side FIFO logic into the 32-bit dword stream consumed by the communication core (FT601 or Ethernet).
- Each 64-bit word is split into two dwords, upper half first. This is the exact inverse of the 32→64 packing on the receive path.
- Before data, and after idle gaps or on request, the block inserts the two-dword resync preamble 0x66665555, 0x66665555 so the far-end packer realigns.
- It sits between the 64-bit command/loopback sources and the 32-bit `com_tx` FIFO in `clk_com`.

## Interface
Parameters:
- `MAGIC`, 32'h66665555: resync dword, always emitted twice back-to-back.
- `RESYNC_IDLE_CYCLES`, 64: consecutive idle cycles after which a new preamble becomes pending; legal range 1..65535.

Ports:
- `clk`  in  1: communication clock; all logic is on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `din`  in  64: input word; [63:32] is sent first.
- `din_valid`  in  1: `din` is valid.
- `din_ready`  out  1: the block accepts `din` this cycle.
- `dout`  out  32: output dword, registered.
- `dout_valid`  out  1: `dout` is valid, registered.
- `dout_ready`  in  1: downstream accepts `dout`.
- `resync_req`  in  1: single-cycle pulse that forces a preamble before the next data dword.
- `busy`  out  1: a word is held or a dword is pending output.
- `tx_dword_cnt`  out  32: count of completed `dout` handshakes, including magic dwords; wraps.

## Operation
- Handshake rule: a transfer occurs when valid and ready are both high. `dout` and `dout_valid` hold stable until accepted.
- Storage: one 64-bit hold register with a `hold_full` flag, plus the output register.
- `advance` = `~dout_valid | dout_ready`. The output register loads only when `advance` is high.
- FSM states, meaning the next dword to load:
  - IDLE: when `advance` and `hold_full`:
    - if `sync_pending`, load `MAGIC` → SYNC1;
    - else load `hold[63:32]` → LO.
  - If `advance` and `~hold_full`, clear `dout_valid` and stay in IDLE.
  - SYNC1: on `advance`, load `MAGIC`, clear `sync_pending` → HI.
  - HI: on `advance`, load `hold[63:32]` → LO.
  - LO: on `advance`, load `hold[31:0]` and free the hold register → IDLE.
- `din_ready` = `~hold_full | (state==LO & advance)`. It is combinational from `dout_ready`; this is deliberate and gives 1 dword/cycle sustained throughput.
- When a new word is accepted in the same cycle as the LO load:
  - `hold_full` stays set;
  - the next state is IDLE, which immediately loads the HI dword next cycle (or `MAGIC` if a preamble is pending).
- `sync_pending` is set by:
  - reset;
  - `resync_req`, honoured in any state;
  - the idle counter reaching `RESYNC_IDLE_CYCLES`.
- A preamble already in progress (state SYNC1) is not repeated. A `resync_req` arriving during SYNC1 → HI is honoured by the next word, because the request sets the flag after the clear has priority-ordered (set wins over clear in the same cycle).
- A `resync_req` arriving during HI/LO never splits a word; the preamble precedes the next word.
- Idle counter:
  - increments each cycle that `~busy`;
  - resets to 0 on any cycle where `busy` is set;
  - saturates at `RESYNC_IDLE_CYCLES`.
- `busy` = `hold_full | dout_valid`.
- `tx_dword_cnt` increments on every `dout` handshake and wraps from 0xFFFFFFFF to 0.
- Payload containing a `MAGIC` pair at an odd dword alignment will falsely resync the far end. Avoiding this is the sender's responsibility; the block does not escape it.

## Timing
- Reset values (asynchronous): `dout`=0, `dout_valid`=0, `din_ready`=1, `busy`=0, `tx_dword_cnt`=0, state=IDLE, `hold_full`=0, `sync_pending`=1, idle counter=0.
- Latency: word accepted at edge N → first dword (`MAGIC` or HI) valid after edge N+1.
- With `dout_ready` held high:
  - preamble + word = 4 consecutive dwords;
  - back-to-back words give continuous dword output with no bubbles.
- Backpressure: with `dout_ready` low, all state freezes and `din_ready` equals `~hold_full`.
- Reset mid-word: the partially sent word is discarded and the preamble is re-armed.

## Structure
- Shared package `pcileech_com_pkg`:
  - `COM_MAGIC_RESYNC` = 32'h66665555;
  - the FSM state enum `com_tx_state_t` {IDLE, SYNC1, HI, LO}, shared with the receive-side packer for lockstep checks.
- Single module with no sub-modules; the idle counter is inline.

## Test plan
- Reset, then one word 64'h11112222_33334444 with `dout_ready`=1 → dout sequence 66665555, 66665555, 11112222, 33334444 on consecutive cycles; `tx_dword_cnt`=4.
- Three back-to-back words while `busy` → one preamble only, then 6 data dwords with no gaps; `din_ready` high every other cycle.
- `dout_ready` toggled randomly (50%) over 1000 words → output equals the reference serialization; `dout` is stable while stalled.
- Idle for exactly `RESYNC_IDLE_CYCLES`-1 cycles between words → no preamble; idle for exactly `RESYNC_IDLE_CYCLES` cycles → preamble inserted.
- `resync_req` pulsed during LO of word A → A completes intact, then a preamble, then word B.
- Force `tx_dword_cnt` to 0xFFFFFFFE, send one word without preamble → counter reads 0 after 2 dwords; assert `rst_n` low during HI → `dout_valid`=0 immediately and the next word is preceded by a preamble.

Source files
------------

// File: rtl/pcileech_com_pkg.sv
// Shared definitions for the 32-bit com stream framing.
// Resync magic dword and the tx/rx lockstep state encoding.
package pcileech_com_pkg;

  localparam logic [31:0] COM_MAGIC_RESYNC = 32'h66665555;

  typedef enum logic [1:0] {
    IDLE,
    SYNC1,
    HI,
    LO
  } com_tx_state_t;

endpackage

// File: rtl/pcileech_com_tx64to32.sv
// 64->32 serializer: upper dword first, resync preamble on start/idle/request.
// Ports: clk, rst_n, din/din_valid/din_ready, dout/dout_valid/dout_ready, resync_req, busy, tx_dword_cnt.
module pcileech_com_tx64to32
  import pcileech_com_pkg::*;
#(
  parameter logic [31:0] MAGIC              = COM_MAGIC_RESYNC,
  parameter int          RESYNC_IDLE_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [31:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  input  logic        resync_req,
  output logic        busy,
  output logic [31:0] tx_dword_cnt
);

  localparam logic [15:0] IDLE_MAX  = 16'(RESYNC_IDLE_CYCLES);
  localparam logic [15:0] IDLE_LAST = 16'(RESYNC_IDLE_CYCLES - 1);

  com_tx_state_t state, state_nxt;
  logic [63:0]   hold;
  logic          hold_full;
  logic          sync_pending;
  logic [15:0]   idle_cnt;

  logic [31:0]   dout_nxt;
  logic          dval_nxt;
  logic          sync_clr;
  logic          hold_free;
  logic          advance;
  logic          accept;
  logic          dout_hs;
  logic          idle_hit;

  assign advance   = ~dout_valid | dout_ready;
  assign din_ready = ~hold_full | ((state == LO) & advance);
  assign accept    = din_valid & din_ready;
  assign dout_hs   = dout_valid & dout_ready;
  assign busy      = hold_full | dout_valid;
  // Fires on the idle cycle that brings the counter up to the limit.
  assign idle_hit  = ~busy & (idle_cnt == IDLE_LAST);

  always_comb begin
    state_nxt = state;
    dout_nxt  = dout;
    dval_nxt  = dout_valid;
    sync_clr  = 1'b0;
    hold_free = 1'b0;
    if (advance) begin
      unique case (state)
        IDLE: begin
          if (hold_full) begin
            dval_nxt = 1'b1;
            if (sync_pending) begin
              dout_nxt  = MAGIC;
              state_nxt = SYNC1;
            end else begin
              dout_nxt  = hold[63:32];
              state_nxt = LO;
            end
          end else begin
            dval_nxt = 1'b0;
          end
        end
        SYNC1: begin
          dout_nxt  = MAGIC;
          dval_nxt  = 1'b1;
          sync_clr  = 1'b1;
          state_nxt = HI;
        end
        HI: begin
          dout_nxt  = hold[63:32];
          dval_nxt  = 1'b1;
          state_nxt = LO;
        end
        LO: begin
          dout_nxt  = hold[31:0];
          dval_nxt  = 1'b1;
          hold_free = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      dout       <= dout_nxt;
      dout_valid <= dval_nxt;
    end
  end

  // A word taken during the LO load keeps the hold register full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      if (accept) hold <= din;
      if (accept) hold_full <= 1'b1;
      else if (hold_free) hold_full <= 1'b0;
    end
  end

  // Set beats clear so a request during SYNC1 still covers the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pending <= 1'b1;
    else if (resync_req | idle_hit) sync_pending <= 1'b1;
    else if (sync_clr) sync_pending <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_cnt <= '0;
    else if (busy) idle_cnt <= '0;
    else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_dword_cnt <= '0;
    else if (dout_hs) tx_dword_cnt <= tx_dword_cnt + 32'd1;
  end

endmodule

// File: tb/tb_pcileech_com_tx64to32.sv
// Scoreboard bench for pcileech_com_tx64to32.
// Expected dwords are queued on word acceptance and popped on dout handshakes.
module tb_pcileech_com_tx64to32;
  import pcileech_com_pkg::*;

  localparam int          R = 8;
  localparam logic [31:0] M = 32'h66665555;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        resync_req;
  logic        busy;
  logic [31:0] tx_dword_cnt;

  always #5 clk = ~clk;

  pcileech_com_tx64to32 #(
    .MAGIC(M),
    .RESYNC_IDLE_CYCLES(R)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .din(din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .resync_req(resync_req),
    .busy(busy),
    .tx_dword_cnt(tx_dword_cnt)
  );

  logic [31:0] q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  bit          mon_en = 1'b0;
  bit          rnd_en = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] stall_val;
  logic [31:0] mon_exp;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev) begin
        chk("stall_valid", dout_valid, 1);
        chk("stall_dout", dout, stall_val);
      end
      if (dout_valid && dout_ready) begin
        if (q.size() == 0) chk("extra_dout", q.size(), 1);
        else begin
          mon_exp = q.pop_front();
          chk("dout", dout, mon_exp);
        end
      end
      stall_prev = dout_valid && !dout_ready;
      stall_val  = dout;
    end
  end

  always @(posedge clk) begin
    if (rnd_en) begin
      #1 dout_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_word(input logic [63:0] w, input bit pre,
                           input bit now, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    din = w;
    din_valid = 1'b1;
    if (now && din_ready) ok = 1'b1;
    while (!ok && waits < 200) begin
      @(negedge clk);
      waits++;
      if (din_ready) ok = 1'b1;
    end
    chk("din_accept", ok, 1);
    if (ok) begin
      if (pre) begin
        q.push_back(M);
        q.push_back(M);
      end
      q.push_back(w[63:32]);
      q.push_back(w[31:0]);
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  // n counts idle cycles including the accepting cycle.
  task automatic idle_then_send(input int n, input logic [63:0] w,
                                input bit pre);
    int k;
    int waits;
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      if (!busy) break;
      k++;
    end
    chk("idle_start", busy, 0);
    repeat (n - 1) @(negedge clk);
    send_word(w, pre, 1'b1, waits);
  endtask

  task automatic drain();
    for (int i = 0; i < 500; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", q.size(), 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int          w;
    int          found;
    logic [31:0] c0;
    logic [63:0] a;

    rst_n = 1'b0;
    din = '0;
    din_valid = 1'b0;
    dout_ready = 1'b1;
    resync_req = 1'b0;
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_din_ready", din_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", tx_dword_cnt, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // single word after reset: preamble + 2 dwords, consecutive
    send_word(64'h11112222_33334444, 1'b1, 1'b0, w);
    repeat (5) @(posedge clk);
    #1;
    chk("t1_cnt", tx_dword_cnt, 4);
    chk("t1_idle_valid", dout_valid, 0);

    // three back-to-back words, single preamble, no bubbles
    repeat (R + 4) @(posedge clk);
    #1;
    send_word(64'hAAAA0001_BBBB0001, 1'b1, 1'b0, w);
    c0 = tx_dword_cnt;
    send_word(64'hAAAA0002_BBBB0002, 1'b0, 1'b0, w);
    chk("t2_wait_w2", w, 4);
    send_word(64'hAAAA0003_BBBB0003, 1'b0, 1'b0, w);
    chk("t2_wait_w3", w, 2);
    chk("t2_cnt_mid", tx_dword_cnt - c0, 5);
    repeat (3) @(posedge clk);
    #1;
    chk("t2_cnt_end", tx_dword_cnt - c0, 8);
    drain();

    // random backpressure over a continuous word stream
    repeat (R + 4) @(posedge clk);
    #1;
    rnd_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send_word({$urandom, $urandom}, i == 0, 1'b0, w);
    end
    rnd_en = 1'b0;
    @(posedge clk);
    #2;
    dout_ready = 1'b1;
    drain();

    // idle threshold: R-1 cycles no preamble, R cycles preamble
    repeat (R + 2) @(posedge clk);
    #1;
    send_word(64'h01020304_05060708, 1'b1, 1'b0, w);
    idle_then_send(R - 1, 64'h10203040_50607080, 1'b0);
    idle_then_send(R, 64'h0A0B0C0D_0E0F1011, 1'b1);

    // resync request during LO of word A
    a = 64'hCAFE0001_BEEF0002;
    idle_then_send(1, a, 1'b0);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dout_valid && dout == a[63:32]) begin
        found = 1;
        break;
      end
    end
    chk("t5_a_hi_seen", found, 1);
    resync_req = 1'b1;
    @(posedge clk);
    #1;
    resync_req = 1'b0;
    send_word(64'hD00D0003_F00D0004, 1'b1, 1'b0, w);
    drain();

    // counter wrap
    force dut.tx_dword_cnt = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.tx_dword_cnt;
    chk("t6_forced", tx_dword_cnt, 32'hFFFF_FFFE);
    send_word(64'h12345678_9ABCDEF0, 1'b0, 1'b0, w);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_cnt_ff", tx_dword_cnt, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    chk("t6_cnt_wrap", tx_dword_cnt, 0);
    drain();

    // reset while in HI (second magic on the wire)
    @(posedge clk);
    #1;
    resync_req = 1'b1;
    @(posedge clk);
    #1;
    resync_req = 1'b0;
    mon_en = 1'b0;
    send_word(64'h55550000_77770000, 1'b1, 1'b0, w);
    q.delete();
    repeat (3) @(negedge clk);
    chk("t7_magic2", dout, M);
    chk("t7_magic2_valid", dout_valid, 1);
    chk("t7_cnt_pre", tx_dword_cnt, 1);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", dout_valid, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_din_ready", din_ready, 1);
    chk("t7_rst_cnt", tx_dword_cnt, 0);
    chk("t7_rst_dout", dout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stall_prev = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    send_word(64'h87654321_0FEDCBA9, 1'b1, 1'b0, w);
    drain();
    chk("t7_cnt_after", tx_dword_cnt, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
